// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the multiplier-sharing controller and its tag FIFO.
// Latency: none, declarations and pure functions only.
// Backpressure: not applicable.
package mult_share_pkg;

    localparam int LAT_DEF = 8;

    // Tag layout is {requester index, result sign}.
    function automatic int tag_width(input int nreq);
        return $clog2(nreq) + 1;
    endfunction

    typedef struct packed {
        logic       neg;
        logic [7:0] mag_a;
        logic [7:0] mag_b;
    } sm_op_t;

    // -128 negates to itself, which is exactly the 8'h80 magnitude the multiplier expects.
    function automatic logic [7:0] to_mag(input logic [7:0] x, input logic sgn);
        return (sgn && x[7]) ? (~x + 8'd1) : x;
    endfunction

    function automatic sm_op_t to_sm(input logic [7:0] a, input logic [7:0] b, input logic sgn);
        sm_op_t r;
        r.mag_a = to_mag(a, sgn);
        r.mag_b = to_mag(b, sgn);
        r.neg   = sgn && (a[7] ^ b[7]) && (|r.mag_a) && (|r.mag_b);
        return r;
    endfunction

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Issue/return bus between the sharing controller and the shared pipelined multiplier.
// Latency: wires only.
// Backpressure: none on this bus; the controller bounds in-flight issues itself.
interface mult_share_ctrl_if;
    logic        mult_en;
    logic [7:0]  mult_a;
    logic [7:0]  mult_b;
    logic [15:0] mult_result;
    logic        mult_rdy;

    modport master (output mult_en, output mult_a, output mult_b,
                    input  mult_result, input mult_rdy);
    modport slave  (input  mult_en, input mult_a, input mult_b,
                    output mult_result, output mult_rdy);
endinterface

// File: rtl/mult_tag_fifo.sv
// Synchronous FIFO with first-word fall-through read and occupancy count.
// Latency: written entry visible on pop_dat the cycle after push.
// Backpressure: push ignored when full unless a pop happens the same cycle.
module mult_tag_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_dat,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_dat,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin sharing of one pipelined 8x8 multiplier among NREQ requesters, sign-magnitude wrapped.
// Latency: gnt same cycle as req, multiplier issue one cycle later; response one cycle after mult_rdy.
// Backpressure: grants stall while LAT ops are in flight, unless a result returns that same cycle.
module mult_share_ctrl import mult_share_pkg::*; #(
    parameter int NREQ   = 4,
    parameter int LAT    = LAT_DEF,
    parameter int SIGNED = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    op_a,
    input  logic [8*NREQ-1:0]    op_b,
    output logic [NREQ-1:0]      gnt,
    mult_share_ctrl_if.master    mul,
    output logic [NREQ-1:0]      resp_valid,
    output logic [15:0]          resp_data,
    output logic                 busy,
    output logic                 err
);
    localparam int   IDX_W = $clog2(NREQ);
    localparam int   TAG_W = tag_width(NREQ);
    localparam int   CNT_W = $clog2(LAT+1);
    localparam logic SGN   = (SIGNED != 0);

    logic [7:0]       opa_arr [NREQ];
    logic [7:0]       opb_arr [NREQ];
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] next_ptr;
    logic [IDX_W-1:0] cand;
    logic [IDX_W:0]   cand_w;
    logic             found;
    logic [7:0]       sel_a;
    logic [7:0]       sel_b;
    sm_op_t           sm;
    logic             issue;
    logic             pop;
    logic [TAG_W-1:0] push_tag;
    logic [TAG_W-1:0] rd_tag;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            opa_arr[k] = op_a[8*k +: 8];
            opb_arr[k] = op_b[8*k +: 8];
        end
    end

    // Cyclic search starting at rr_ptr; first hit wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sel_a  = '0;
        sel_b  = '0;
        cand_w = '0;
        cand   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_w = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand_w >= (IDX_W+1)'(NREQ)) cand_w = cand_w - (IDX_W+1)'(NREQ);
            cand = cand_w[IDX_W-1:0];
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
                sel_a  = opa_arr[cand];
                sel_b  = opb_arr[cand];
            end
        end
    end

    assign next_ptr = (winner == IDX_W'(NREQ-1)) ? '0 : winner + 1'b1;
    assign sm       = to_sm(sel_a, sel_b, SGN);
    assign pop      = mul.mult_rdy && !fifo_empty;
    // Gated by rst_n so gnt drops immediately on asynchronous reset.
    assign issue    = rst_n && found && (!fifo_full || pop);
    assign gnt      = issue ? (NREQ'(1) << winner) : '0;
    assign push_tag = {winner, sm.neg};
    assign busy     = (fifo_count != '0) || mul.mult_en;

    mult_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (LAT)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (issue),
        .push_dat (push_tag),
        .pop      (pop),
        .pop_dat  (rd_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            mul.mult_en <= 1'b0;
            mul.mult_a  <= '0;
            mul.mult_b  <= '0;
            resp_valid  <= '0;
            resp_data   <= '0;
            err         <= 1'b0;
        end else begin
            mul.mult_en <= issue;
            if (issue) begin
                mul.mult_a <= sm.mag_a;
                mul.mult_b <= sm.mag_b;
                rr_ptr     <= next_ptr;
            end
            resp_valid <= '0;
            if (mul.mult_rdy) begin
                if (!fifo_empty) begin
                    resp_valid <= NREQ'(1) << rd_tag[TAG_W-1:1];
                    resp_data  <= rd_tag[0] ? (~mul.mult_result + 16'd1) : mul.mult_result;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Shares one pipelined 8x8 shift-add multiplier (mult_top_1 instance, external to this block) between NREQ requesters, e.g. the real/imag product paths of an FFT butterfly.
- Round-robin arbitration; at most one issue per cycle.
- Optional signed mode: operands go to the multiplier as sign-magnitude, and the sign is re-applied on return.
- A tag FIFO routes each result back to the requester that issued it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 8, multiplier pipeline depth; sets tag FIFO depth and the in-flight limit.
- SIGNED, 1, 1 = operands and results are two's complement; 0 = unsigned pass-through.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- req  in  NREQ  per-requester operation request, level; held until granted.
- op_a  in  8*NREQ  operand A, requester k at bits [8k+7:8k].
- op_b  in  8*NREQ  operand B, same packing.
- gnt  out  NREQ  one-hot, one-cycle pulse: operands of that requester captured this cycle.
- mult_en  out  1  issue strobe to multiplier en.
- mult_a  out  8  multiplier operand 1 (magnitude).
- mult_b  out  8  multiplier operand 2 (magnitude).
- mult_result  in  16  multiplier product.
- mult_rdy  in  1  multiplier product valid.
- resp_valid  out  NREQ  one-hot, one-cycle pulse: resp_data belongs to that requester.
- resp_data  out  16  product; signed 16-bit if SIGNED=1.
- busy  out  1  at least one operation in flight.
- err  out  1  sticky: mult_rdy arrived with tag FIFO empty.

Interface: single clock clk; rst_n is asynchronous, active-low.

Behaviour:
- Reset: all outputs 0, rr pointer = 0, FIFO empty, err = 0. Reset mid-operation drops all in-flight tags; a mult_rdy seen after reset with an empty FIFO sets err.
- Issue condition: |req and FIFO count < LAT.
  - Winner = first set req at or after rr pointer, searching cyclically upward.
  - Same cycle: gnt[winner] = 1; mult_en, mult_a, mult_b registered, so the multiplier sees them one cycle after gnt (issue latency 1).
  - Tag pushed: {winner index, result sign}.
  - rr pointer <- winner + 1 mod NREQ.
  - No request, or FIFO full: gnt = 0, mult_en = 0 next cycle, pointer unchanged.
- Operand conversion, SIGNED=1:
  - mag = |x|; -128 maps to 8'h80.
  - sign = a[7] ^ b[7], forced to 0 if either magnitude is 0.
- Operand conversion, SIGNED=0: operands pass through unchanged; sign = 0.
- Return path on mult_rdy:
  - Pop tag.
  - Register resp_data = sign ? -mult_result : mult_result.
  - Pulse resp_valid[tag index]; outputs appear one cycle after mult_rdy.
  - Magnitude max 16384, so the negation fits 16 bits.
- Simultaneous push and pop: count unchanged, both operations performed. Full plus pop in the same cycle allows issue that cycle.
- Pop on empty FIFO: err <- 1 (sticky until reset), resp_valid stays 0, no pointer movement.
- busy = (count != 0) or mult_en pending.
- Requester hold rule: a requester drops req the cycle after its gnt, or holds req to request again. Back-to-back grants to the same requester are legal only when it is the sole requester.
- FIFO: LAT entries, wrap-around read/write pointers, count register; width = clog2(NREQ) + 1.
- Throughput: one op per cycle sustained; results return in issue order.

Decomposition:
- Package mult_share_pkg holds:
  - tag struct/width constant (TAG_W = clog2(NREQ) + 1);
  - default LAT = 8;
  - sign-magnitude conversion function.
- Sub-module mult_tag_fifo: synchronous FIFO with parameterised WIDTH/DEPTH, full, empty, count outputs and simultaneous push/pop. Arbiter and sign logic stay in the top.

Test Plan:
- Single op, SIGNED=1: requester 2 issues a=-3, b=5.
  - gnt[2] pulse; mult_en next cycle with 3, 5.
  - Model mult_rdy 8 cycles later with 15 → resp_valid[2], resp_data = 16'hFFF1 (-15).
- Round-robin: all 4 req held from reset → gnt order 0, 1, 2, 3, 0…; no requester starves over 16 cycles.
- Full stall, LAT=8 with multiplier model returning nothing:
  - 8 grants occur, then gnt stays 0 and busy = 1.
  - One mult_rdy → exactly one further grant in that same cycle.
- Boundary operands: (-128) × (-128) → 16384 (16'h4000); (-128) × 127 → -16256 (16'hC080); 0 × (-5) → 16'h0000, sign 0.
- Spurious mult_rdy after reset with no issue → err = 1, resp_valid all 0; err persists until rst_n low.
- Reset mid-stream: assert rst_n low with 5 ops in flight → all outputs 0 immediately (asynchronous); after release the FIFO is empty and the first new op returns to the correct requester.
